// File: rtl/fetch_pkg.sv
// Shared defaults and control-priority encoding for the instruction-fetch stage.
package fetch_pkg;

    localparam int unsigned FETCH_DATA_W = 60;
    localparam int unsigned FETCH_PC_W   = 16;
    localparam logic [FETCH_DATA_W-1:0] FETCH_NOP_WORD = {1'b1, 59'b0};

    typedef enum logic [1:0] {
        CTL_REDIRECT,
        CTL_BRANCH,
        CTL_FLUSH,
        CTL_NONE
    } ctl_e;

endpackage

// File: rtl/fetch_queue.sv
// Circular buffer of {pc,data} bundles with push/pop/clear and an occupancy count.
module fetch_queue
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_W = FETCH_DATA_W,
    parameter int unsigned PC_W   = FETCH_PC_W,
    parameter int unsigned DEPTH  = 4,
    localparam int unsigned CNT_W = $clog2(DEPTH + 1)
)(
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_push,
    input  logic              i_pop,
    input  logic              i_clear,
    input  logic [PC_W-1:0]   i_pc,
    input  logic [DATA_W-1:0] i_data,
    output logic [PC_W-1:0]   o_head_pc,
    output logic [DATA_W-1:0] o_head_data,
    output logic [CNT_W-1:0]  o_count
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [PC_W-1:0]   r_pc_q   [DEPTH];
    logic [DATA_W-1:0] r_data_q [DEPTH];
    logic [PTR_W-1:0]  r_head;
    logic [PTR_W-1:0]  r_tail;
    logic [CNT_W-1:0]  r_count;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (i_clear) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            if (i_push) r_tail <= ptr_inc(r_tail);
            if (i_pop)  r_head <= ptr_inc(r_head);
            if (i_push && !i_pop)
                r_count <= r_count + CNT_W'(1);
            else if (!i_push && i_pop)
                r_count <= r_count - CNT_W'(1);
        end
    end

    // Payload storage needs no reset; occupancy gates its visibility.
    always_ff @(posedge i_clk) begin
        if (i_push && !i_clear) begin
            r_pc_q[r_tail]   <= i_pc;
            r_data_q[r_tail] <= i_data;
        end
    end

    assign o_head_pc   = r_pc_q[r_head];
    assign o_head_data = r_data_q[r_head];
    assign o_count     = r_count;

endmodule

// File: rtl/fetch_queue_unit.sv
// Fetch stage: PC register, loadable instruction store, control priority and bundle queue.
module fetch_queue_unit
    import fetch_pkg::*;
#(
    parameter int unsigned DATA_W     = FETCH_DATA_W,
    parameter int unsigned PC_W       = FETCH_PC_W,
    parameter int unsigned DEPTH      = 128,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter logic [PC_W-1:0]   RESET_PC = '0,
    parameter logic [DATA_W-1:0] NOP_WORD = {1'b1, {(DATA_W - 1){1'b0}}},
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1)
)(
    input  logic              clock_i,
    input  logic              reset_i,
    input  logic              imem_we_i,
    input  logic [PC_W-1:0]   imem_waddr_i,
    input  logic [DATA_W-1:0] imem_wdata_i,
    input  logic              redirect_i,
    input  logic [PC_W-1:0]   redirect_pc_i,
    input  logic              branch_i,
    input  logic [PC_W-1:0]   branch_pc_i,
    input  logic [PC_W-1:0]   branch_offset_i,
    input  logic              branch_dir_i,
    input  logic              flush_i,
    input  logic              halt_i,
    input  logic              ready_i,
    output logic              valid_o,
    output logic [DATA_W-1:0] data_o,
    output logic [PC_W-1:0]   pc_o,
    output logic [CNT_W-1:0]  count_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PC_W-1:0]   r_pc;

    ctl_e              w_ctl;
    logic              w_clear;
    logic              w_pop;
    logic              w_push;
    logic              w_valid;
    logic [PC_W-1:0]   w_pc_nxt;
    logic [PC_W-1:0]   w_branch_tgt;
    logic [PC_W-1:0]   w_head_pc;
    logic [DATA_W-1:0] w_head_data;
    logic [DATA_W-1:0] w_fetch_data;
    logic [CNT_W-1:0]  w_count;

    // Store writes land at the edge, so a same-cycle fetch still reads the old word.
    always_ff @(posedge clock_i) begin
        if (imem_we_i && (imem_waddr_i < PC_W'(DEPTH)))
            r_mem[imem_waddr_i[AW-1:0]] <= imem_wdata_i;
    end

    assign w_fetch_data = (r_pc < PC_W'(DEPTH)) ? r_mem[r_pc[AW-1:0]] : NOP_WORD;
    assign w_branch_tgt = branch_dir_i ? (branch_pc_i + branch_offset_i)
                                       : (branch_pc_i - branch_offset_i);
    assign w_valid      = (w_count != '0);

    always_comb begin
        w_ctl = CTL_NONE;
        if (redirect_i)    w_ctl = CTL_REDIRECT;
        else if (branch_i) w_ctl = CTL_BRANCH;
        else if (flush_i)  w_ctl = CTL_FLUSH;
    end

    // Any control event clears the queue and suppresses the push; a pop that cycle is lost.
    always_comb begin
        w_pc_nxt = r_pc;
        w_clear  = 1'b0;
        w_push   = 1'b0;
        w_pop    = w_valid & ready_i;
        case (w_ctl)
            CTL_REDIRECT: begin
                w_clear  = 1'b1;
                w_pc_nxt = redirect_pc_i;
            end
            CTL_BRANCH: begin
                w_clear  = 1'b1;
                w_pc_nxt = w_branch_tgt;
            end
            CTL_FLUSH: begin
                w_clear  = 1'b1;
            end
            default: begin
                w_push = !halt_i && ((w_count < CNT_W'(FIFO_DEPTH)) || w_pop);
                if (w_push) w_pc_nxt = r_pc + PC_W'(1);
            end
        endcase
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) r_pc <= RESET_PC;
        else         r_pc <= w_pc_nxt;
    end

    fetch_queue #(
        .DATA_W (DATA_W),
        .PC_W   (PC_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_queue (
        .i_clk       (clock_i),
        .i_rst       (reset_i),
        .i_push      (w_push),
        .i_pop       (w_pop),
        .i_clear     (w_clear),
        .i_pc        (r_pc),
        .i_data      (w_fetch_data),
        .o_head_pc   (w_head_pc),
        .o_head_data (w_head_data),
        .o_count     (w_count)
    );

    assign valid_o = w_valid;
    assign data_o  = w_valid ? w_head_data : '0;
    assign pc_o    = w_valid ? w_head_pc : '0;
    assign count_o = w_count;

endmodule

// File: tb/tb_fetch_queue_unit.sv
// Directed bench for fetch_queue_unit: streaming, back-pressure, branches, priority, halt, reset.
module tb_fetch_queue_unit;

    localparam int unsigned DW = 60;
    localparam int unsigned PW = 16;

    logic          clock_i = 1'b0;
    logic          reset_i = 1'b1;
    logic          imem_we_i = 1'b0;
    logic [PW-1:0] imem_waddr_i = '0;
    logic [DW-1:0] imem_wdata_i = '0;
    logic          redirect_i = 1'b0;
    logic [PW-1:0] redirect_pc_i = '0;
    logic          branch_i = 1'b0;
    logic [PW-1:0] branch_pc_i = '0;
    logic [PW-1:0] branch_offset_i = '0;
    logic          branch_dir_i = 1'b0;
    logic          flush_i = 1'b0;
    logic          halt_i = 1'b0;
    logic          ready_i = 1'b0;
    logic          valid_o;
    logic [DW-1:0] data_o;
    logic [PW-1:0] pc_o;
    logic [2:0]    count_o;

    int n_cmp = 0;
    int n_err = 0;

    fetch_queue_unit dut (
        .clock_i         (clock_i),
        .reset_i         (reset_i),
        .imem_we_i       (imem_we_i),
        .imem_waddr_i    (imem_waddr_i),
        .imem_wdata_i    (imem_wdata_i),
        .redirect_i      (redirect_i),
        .redirect_pc_i   (redirect_pc_i),
        .branch_i        (branch_i),
        .branch_pc_i     (branch_pc_i),
        .branch_offset_i (branch_offset_i),
        .branch_dir_i    (branch_dir_i),
        .flush_i         (flush_i),
        .halt_i          (halt_i),
        .ready_i         (ready_i),
        .valid_o         (valid_o),
        .data_o          (data_o),
        .pc_o            (pc_o),
        .count_o         (count_o)
    );

    always #5 clock_i = ~clock_i;

    // Program image: tagged word per address; out-of-store addresses return the NOP bundle.
    function automatic logic [DW-1:0] word(input logic [PW-1:0] pc);
        logic [DW-1:0] w;
        w = 60'hA5A000000000000;
        if (pc >= 16'd128) return {1'b1, 59'b0};
        return w | DW'(pc);
    endfunction

    task automatic step();
        @(posedge clock_i);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            imem_we_i    = 1'b1;
            imem_waddr_i = PW'(i);
            imem_wdata_i = word(PW'(i));
            step();
        end
        imem_we_i = 1'b0;
        n_cmp++;
        if ({valid_o, count_o, pc_o, data_o} !== {1'b1 ^ 1'b1, 3'd0, 16'd0, 60'd0}) begin
            n_err++;
            $display("FAIL reset_state got v=%0b cnt=%0d pc=%h d=%h exp all zero", valid_o, count_o, pc_o, data_o);
        end
    endtask

    task automatic test_stream();
        logic [PW-1:0] e;
        ready_i = 1'b1;
        reset_i = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            e = PW'(k);
            n_cmp++;
            if ({valid_o, pc_o, data_o} !== {1'b1, e, word(e)}) begin
                n_err++;
                $display("FAIL stream[%0d] got v=%0b pc=%h d=%h exp pc=%h d=%h", k, valid_o, pc_o, data_o, e, word(e));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [PW-1:0] e;
        logic [2:0]    ec;
        ready_i = 1'b0;
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step();
            ec = (k < 4) ? 3'(k) : 3'd4;
            n_cmp++;
            if ({count_o, valid_o, pc_o, data_o} !== {ec, 1'b1, 16'd0, word(16'd0)}) begin
                n_err++;
                $display("FAIL bp_hold[%0d] got cnt=%0d v=%0b pc=%h exp cnt=%0d pc=0", k, count_o, valid_o, pc_o, ec);
            end
        end
        ready_i = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            step();
            e = PW'(k);
            n_cmp++;
            if ({count_o, valid_o, pc_o, data_o} !== {3'd4, 1'b1, e, word(e)}) begin
                n_err++;
                $display("FAIL bp_drain[%0d] got cnt=%0d v=%0b pc=%h exp cnt=4 pc=%h", k, count_o, valid_o, pc_o, e);
            end
        end
    endtask

    task automatic test_branch_fwd();
        branch_i = 1'b1; branch_pc_i = 16'd10; branch_offset_i = 16'd5; branch_dir_i = 1'b1;
        step();
        branch_i = 1'b0;
        n_cmp++;
        if ({valid_o, count_o, pc_o, data_o} !== {1'b0, 3'd0, 16'd0, 60'd0}) begin
            n_err++;
            $display("FAIL brf_clear got v=%0b cnt=%0d pc=%h d=%h exp empty", valid_o, count_o, pc_o, data_o);
        end
        step();
        n_cmp++;
        if ({valid_o, count_o, pc_o, data_o} !== {1'b1, 3'd1, 16'd15, word(16'd15)}) begin
            n_err++;
            $display("FAIL brf_target got v=%0b cnt=%0d pc=%h exp pc=000f cnt=1", valid_o, count_o, pc_o);
        end
        step();
        n_cmp++;
        if ({valid_o, pc_o, data_o} !== {1'b1, 16'd16, word(16'd16)}) begin
            n_err++;
            $display("FAIL brf_next got v=%0b pc=%h exp pc=0010", valid_o, pc_o);
        end
    endtask

    task automatic test_branch_back();
        logic [PW-1:0] e;
        branch_i = 1'b1; branch_pc_i = 16'd2; branch_offset_i = 16'd5; branch_dir_i = 1'b0;
        step();
        branch_i = 1'b0;
        n_cmp++;
        if ({valid_o, count_o} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL brb_clear got v=%0b cnt=%0d exp v=0 cnt=0", valid_o, count_o);
        end
        for (int k = 0; k < 4; k++) begin
            step();
            e = 16'hFFFD + PW'(k);
            n_cmp++;
            if ({valid_o, pc_o, data_o} !== {1'b1, e, word(e)}) begin
                n_err++;
                $display("FAIL brb_wrap[%0d] got v=%0b pc=%h d=%h exp pc=%h d=%h", k, valid_o, pc_o, data_o, e, word(e));
            end
        end
    endtask

    task automatic test_priority();
        redirect_i = 1'b1; redirect_pc_i = 16'd7;
        branch_i = 1'b1; branch_pc_i = 16'd10; branch_offset_i = 16'd5; branch_dir_i = 1'b1;
        step();
        redirect_i = 1'b0; branch_i = 1'b0;
        step();
        n_cmp++;
        if ({valid_o, pc_o, data_o} !== {1'b1, 16'd7, word(16'd7)}) begin
            n_err++;
            $display("FAIL prio_redirect got v=%0b pc=%h exp pc=0007", valid_o, pc_o);
        end
        ready_i = 1'b0;
        step();
        step();
        n_cmp++;
        if ({count_o, pc_o} !== {3'd3, 16'd7}) begin
            n_err++;
            $display("FAIL prio_fill got cnt=%0d pc=%h exp cnt=3 pc=0007", count_o, pc_o);
        end
        flush_i = 1'b1;
        step();
        flush_i = 1'b0;
        n_cmp++;
        if ({valid_o, count_o} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL flush_clear got v=%0b cnt=%0d exp v=0 cnt=0", valid_o, count_o);
        end
        ready_i = 1'b1;
        step();
        n_cmp++;
        if ({valid_o, pc_o, data_o} !== {1'b1, 16'd10, word(16'd10)}) begin
            n_err++;
            $display("FAIL flush_held_pc got v=%0b pc=%h exp pc=000a", valid_o, pc_o);
        end
    endtask

    task automatic test_halt();
        halt_i = 1'b1;
        step();
        n_cmp++;
        if ({valid_o, count_o} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL halt_drain got v=%0b cnt=%0d exp v=0 cnt=0", valid_o, count_o);
        end
        step();
        n_cmp++;
        if ({valid_o, count_o} !== {1'b0, 3'd0}) begin
            n_err++;
            $display("FAIL halt_hold got v=%0b cnt=%0d exp v=0 cnt=0", valid_o, count_o);
        end
        halt_i = 1'b0;
        step();
        n_cmp++;
        if ({valid_o, pc_o, data_o} !== {1'b1, 16'd11, word(16'd11)}) begin
            n_err++;
            $display("FAIL halt_resume got v=%0b pc=%h exp pc=000b", valid_o, pc_o);
        end
    endtask

    task automatic test_async_reset();
        step();
        #3;
        reset_i = 1'b1;
        #1;
        n_cmp++;
        if ({valid_o, count_o, pc_o, data_o} !== {1'b0, 3'd0, 16'd0, 60'd0}) begin
            n_err++;
            $display("FAIL async_reset got v=%0b cnt=%0d pc=%h exp all zero", valid_o, count_o, pc_o);
        end
        step();
        reset_i = 1'b0;
        step();
        n_cmp++;
        if ({valid_o, count_o, pc_o, data_o} !== {1'b1, 3'd1, 16'd0, word(16'd0)}) begin
            n_err++;
            $display("FAIL restart0 got v=%0b cnt=%0d pc=%h exp pc=0000 cnt=1", valid_o, count_o, pc_o);
        end
        step();
        n_cmp++;
        if ({valid_o, pc_o, data_o} !== {1'b1, 16'd1, word(16'd1)}) begin
            n_err++;
            $display("FAIL restart1 got v=%0b pc=%h exp pc=0001", valid_o, pc_o);
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_branch_fwd();
        test_branch_back();
        test_priority();
        test_halt();
        test_async_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
